// File: rtl/qdec_cabac_package.sv
// Types and context-index tables shared by the CABAC transform-tree encoder and decoder.
package qdec_cabac_package;

    typedef enum logic [3:0] {
        IDLE_TRAFO           = 4'd0,
        JUDGE_SPLIT_TRAFO    = 4'd1,
        SPLIT_TRANSFORM_FLAG = 4'd2,
        JUDGE_CBF_CHROMA     = 4'd3,
        CBF_CB               = 4'd4,
        CBF_CR               = 4'd5,
        JUDGE_TU             = 4'd6,
        CBF_LUMA             = 4'd7,
        TU_CODING            = 4'd8,
        ITERATION_TRAFO      = 4'd9,
        ENDING_TRAFO         = 4'd10
    } t_state_trafo_enc;

    localparam logic PRED_MODE_INTRA = 1'b1;

    // split_transform_flag context is selected by 5 - log2TrafoSize
    localparam logic [9:0] CTXIDX_SPLIT_TRANSFORM_FLAG [0:2] = '{10'd60, 10'd61, 10'd62};
    localparam logic [9:0] CTXIDX_CBF_CB   [0:4] = '{10'd70, 10'd71, 10'd72, 10'd73, 10'd74};
    localparam logic [9:0] CTXIDX_CBF_CR   [0:4] = '{10'd80, 10'd81, 10'd82, 10'd83, 10'd84};
    localparam logic [9:0] CTXIDX_CBF_LUMA [0:1] = '{10'd90, 10'd91};

    function automatic logic [9:0] ctx_split(input logic [2:0] log2);
        case (log2)
            3'd5:    return CTXIDX_SPLIT_TRANSFORM_FLAG[0];
            3'd4:    return CTXIDX_SPLIT_TRANSFORM_FLAG[1];
            default: return CTXIDX_SPLIT_TRANSFORM_FLAG[2];
        endcase
    endfunction

    function automatic logic [9:0] ctx_cb(input logic [2:0] depth);
        return (depth > 3'd4) ? CTXIDX_CBF_CB[4] : CTXIDX_CBF_CB[depth];
    endfunction

    function automatic logic [9:0] ctx_cr(input logic [2:0] depth);
        return (depth > 3'd4) ? CTXIDX_CBF_CR[4] : CTXIDX_CBF_CR[depth];
    endfunction

    function automatic logic [9:0] ctx_luma(input logic [2:0] depth);
        return (depth == 3'd0) ? CTXIDX_CBF_LUMA[1] : CTXIDX_CBF_LUMA[0];
    endfunction

endpackage

// File: rtl/qenc_trafo_fsm.sv
// Transform-tree walker of the CABAC encoder: emits split/cbf bins and hands leaves to the TU encoder.
module qenc_trafo_fsm
    import qdec_cabac_package::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trafo_start,
    input  logic [2:0]  log2TrafoSize,
    input  logic [2:0]  maxTbLog2SizeY,
    input  logic [2:0]  minTbLog2SizeY,
    input  logic [2:0]  maxTrafoDepth,
    input  logic        intra_split_flag,
    input  logic        pred_mode,
    input  logic [0:0]  split_transform_flag_d0,
    input  logic [3:0]  split_transform_flag_d1,
    input  logic [15:0] split_transform_flag_d2,
    input  logic        cbf_cb_d0,
    input  logic [3:0]  cbf_cb_d1,
    input  logic [15:0] cbf_cb_d2,
    input  logic        cbf_cr_d0,
    input  logic [3:0]  cbf_cr_d1,
    input  logic [15:0] cbf_cr_d2,
    input  logic        cbf_luma_d0,
    input  logic [3:0]  cbf_luma_d1,
    input  logic [15:0] cbf_luma_d2,
    input  logic [63:0] cbf_luma_d3,
    output logic [9:0]  bin_ctx_addr,
    output logic        bin_val,
    output logic        bin_vld,
    input  logic        bin_rdy,
    output logic        EPMode_trafo,
    output logic        tu_start,
    output logic [2:0]  tu_depth,
    output logic [1:0]  tu_blkIdx,
    output logic        tu_cbf_luma,
    output logic        tu_cbf_cb,
    output logic        tu_cbf_cr,
    input  logic        tu_done,
    output logic        trafo_done_intr
);

    t_state_trafo_enc state_q, state_d;
    logic [2:0]       depth_q, depth_d;
    logic [2:0]       log2_q, log2_d;
    logic [4:0][1:0]  blk_q, blk_d;
    logic [4:0]       cb_stk_q, cb_stk_d;
    logic [4:0]       cr_stk_q, cr_stk_d;
    logic             split_q, split_d;
    logic             luma_q, luma_d;
    logic             bin_vld_q, bin_vld_d;
    logic             bin_val_q, bin_val_d;
    logic [9:0]       bin_ctx_q, bin_ctx_d;
    logic             tu_start_q, tu_start_d;
    logic             tu_issued_q, tu_issued_d;
    logic [2:0]       tu_depth_q, tu_depth_d;
    logic [1:0]       tu_blk_q, tu_blk_d;
    logic             tu_luma_q, tu_luma_d;
    logic             tu_cb_q, tu_cb_d;
    logic             tu_cr_q, tu_cr_d;
    logic             done_q, done_d;

    logic [5:0] cur_idx;
    logic       split_in, cb_in, cr_in, luma_in;
    logic [2:0] depth_p1, depth_m1;
    logic       parent_cb, parent_cr;
    logic       split_coded, split_inf;
    logic       cb_coded, cr_coded, chroma_inf_cb, chroma_inf_cr;
    logic       luma_coded;
    logic       chroma_done;

    // z-order index of the current node: parent index * 4 + blkIdx, one 2-bit digit per depth
    always_comb begin
        cur_idx = '0;
        for (int unsigned d = 1; d <= 4; d++) begin
            if (3'(d) <= depth_q) cur_idx = {cur_idx[3:0], blk_q[3'(d)]};
        end
    end

    // select the encoder decisions that belong to the current node
    always_comb begin
        split_in = 1'b0;
        cb_in    = 1'b0;
        cr_in    = 1'b0;
        luma_in  = cbf_luma_d3[cur_idx];
        case (depth_q)
            3'd0: begin
                split_in = split_transform_flag_d0[0];
                cb_in    = cbf_cb_d0;
                cr_in    = cbf_cr_d0;
                luma_in  = cbf_luma_d0;
            end
            3'd1: begin
                split_in = split_transform_flag_d1[cur_idx[1:0]];
                cb_in    = cbf_cb_d1[cur_idx[1:0]];
                cr_in    = cbf_cr_d1[cur_idx[1:0]];
                luma_in  = cbf_luma_d1[cur_idx[1:0]];
            end
            3'd2: begin
                split_in = split_transform_flag_d2[cur_idx[3:0]];
                cb_in    = cbf_cb_d2[cur_idx[3:0]];
                cr_in    = cbf_cr_d2[cur_idx[3:0]];
                luma_in  = cbf_luma_d2[cur_idx[3:0]];
            end
            default: ;
        endcase
    end

    // syntax-element presence and inferred values for the current node
    always_comb begin
        depth_p1      = depth_q + 3'd1;
        depth_m1      = depth_q - 3'd1;
        parent_cb     = (depth_q == 3'd0) ? 1'b1 : cb_stk_q[depth_m1];
        parent_cr     = (depth_q == 3'd0) ? 1'b1 : cr_stk_q[depth_m1];
        split_coded   = (log2_q <= maxTbLog2SizeY) && (log2_q > minTbLog2SizeY) &&
                        (depth_q < maxTrafoDepth) && !(intra_split_flag && depth_q == 3'd0);
        split_inf     = (log2_q > maxTbLog2SizeY) || (intra_split_flag && depth_q == 3'd0);
        cb_coded      = (log2_q > 3'd2) && parent_cb;
        cr_coded      = (log2_q > 3'd2) && parent_cr;
        chroma_inf_cb = (log2_q == 3'd2 && depth_q != 3'd0) ? parent_cb : 1'b0;
        chroma_inf_cr = (log2_q == 3'd2 && depth_q != 3'd0) ? parent_cr : 1'b0;
        luma_coded    = (pred_mode == PRED_MODE_INTRA) || (depth_q != 3'd0) ||
                        cb_stk_q[depth_q] || cr_stk_q[depth_q];
    end

    // tree-walk state machine with bin and TU handshakes
    always_comb begin
        state_d     = state_q;
        depth_d     = depth_q;
        log2_d      = log2_q;
        blk_d       = blk_q;
        cb_stk_d    = cb_stk_q;
        cr_stk_d    = cr_stk_q;
        split_d     = split_q;
        luma_d      = luma_q;
        bin_vld_d   = bin_vld_q;
        bin_val_d   = bin_val_q;
        bin_ctx_d   = bin_ctx_q;
        tu_start_d  = 1'b0;
        tu_issued_d = tu_issued_q;
        tu_depth_d  = tu_depth_q;
        tu_blk_d    = tu_blk_q;
        tu_luma_d   = tu_luma_q;
        tu_cb_d     = tu_cb_q;
        tu_cr_d     = tu_cr_q;
        done_d      = 1'b0;
        chroma_done = 1'b0;

        case (state_q)
            IDLE_TRAFO: begin
                if (trafo_start) begin
                    depth_d = '0;
                    log2_d  = log2TrafoSize;
                    blk_d   = '0;
                    state_d = JUDGE_SPLIT_TRAFO;
                end
            end
            JUDGE_SPLIT_TRAFO: begin
                if (split_coded) begin
                    split_d = split_in;
                    state_d = SPLIT_TRANSFORM_FLAG;
                end else begin
                    split_d = split_inf;
                    state_d = JUDGE_CBF_CHROMA;
                end
            end
            SPLIT_TRANSFORM_FLAG: begin
                if (!bin_vld_q) begin
                    bin_vld_d = 1'b1;
                    bin_val_d = split_q;
                    bin_ctx_d = ctx_split(log2_q);
                end else if (bin_rdy) begin
                    bin_vld_d = 1'b0;
                    state_d   = JUDGE_CBF_CHROMA;
                end
            end
            JUDGE_CBF_CHROMA: begin
                cb_stk_d[depth_q] = cb_coded ? cb_in : chroma_inf_cb;
                cr_stk_d[depth_q] = cr_coded ? cr_in : chroma_inf_cr;
                if (cb_coded)      state_d = CBF_CB;
                else if (cr_coded) state_d = CBF_CR;
                else               chroma_done = 1'b1;
            end
            CBF_CB: begin
                if (!bin_vld_q) begin
                    bin_vld_d = 1'b1;
                    bin_val_d = cb_stk_q[depth_q];
                    bin_ctx_d = ctx_cb(depth_q);
                end else if (bin_rdy) begin
                    bin_vld_d = 1'b0;
                    if (cr_coded) state_d = CBF_CR;
                    else          chroma_done = 1'b1;
                end
            end
            CBF_CR: begin
                if (!bin_vld_q) begin
                    bin_vld_d = 1'b1;
                    bin_val_d = cr_stk_q[depth_q];
                    bin_ctx_d = ctx_cr(depth_q);
                end else if (bin_rdy) begin
                    bin_vld_d   = 1'b0;
                    chroma_done = 1'b1;
                end
            end
            JUDGE_TU: begin
                if (luma_coded) begin
                    luma_d  = luma_in;
                    state_d = CBF_LUMA;
                end else begin
                    luma_d  = 1'b1;
                    state_d = TU_CODING;
                end
            end
            CBF_LUMA: begin
                if (!bin_vld_q) begin
                    bin_vld_d = 1'b1;
                    bin_val_d = luma_q;
                    bin_ctx_d = ctx_luma(depth_q);
                end else if (bin_rdy) begin
                    bin_vld_d = 1'b0;
                    state_d   = TU_CODING;
                end
            end
            TU_CODING: begin
                if (!tu_issued_q) begin
                    tu_start_d  = 1'b1;
                    tu_issued_d = 1'b1;
                    tu_depth_d  = depth_q;
                    tu_blk_d    = blk_q[depth_q];
                    tu_luma_d   = luma_q;
                    tu_cb_d     = cb_stk_q[depth_q];
                    tu_cr_d     = cr_stk_q[depth_q];
                end else if (tu_done) begin
                    tu_issued_d = 1'b0;
                    state_d     = ITERATION_TRAFO;
                end
            end
            // one pop per cycle while the last sibling at a depth has finished
            ITERATION_TRAFO: begin
                if (depth_q == 3'd0) begin
                    state_d = ENDING_TRAFO;
                end else if (blk_q[depth_q] != 2'd3) begin
                    blk_d[depth_q] = blk_q[depth_q] + 2'd1;
                    state_d        = JUDGE_SPLIT_TRAFO;
                end else begin
                    blk_d[depth_q] = '0;
                    depth_d        = depth_m1;
                    log2_d         = log2_q + 3'd1;
                end
            end
            ENDING_TRAFO: begin
                done_d  = 1'b1;
                state_d = IDLE_TRAFO;
            end
            default: state_d = IDLE_TRAFO;
        endcase

        // chroma flags of a node are complete: descend on split, otherwise move to the leaf
        if (chroma_done) begin
            if (split_q) begin
                depth_d         = depth_p1;
                log2_d          = log2_q - 3'd1;
                blk_d[depth_p1] = '0;
                state_d         = JUDGE_SPLIT_TRAFO;
            end else begin
                state_d = JUDGE_TU;
            end
        end
    end

    // state and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE_TRAFO;
            depth_q     <= '0;
            log2_q      <= '0;
            blk_q       <= '0;
            cb_stk_q    <= '0;
            cr_stk_q    <= '0;
            split_q     <= 1'b0;
            luma_q      <= 1'b0;
            bin_vld_q   <= 1'b0;
            bin_val_q   <= 1'b0;
            bin_ctx_q   <= '0;
            tu_start_q  <= 1'b0;
            tu_issued_q <= 1'b0;
            tu_depth_q  <= '0;
            tu_blk_q    <= '0;
            tu_luma_q   <= 1'b0;
            tu_cb_q     <= 1'b0;
            tu_cr_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            log2_q      <= log2_d;
            blk_q       <= blk_d;
            cb_stk_q    <= cb_stk_d;
            cr_stk_q    <= cr_stk_d;
            split_q     <= split_d;
            luma_q      <= luma_d;
            bin_vld_q   <= bin_vld_d;
            bin_val_q   <= bin_val_d;
            bin_ctx_q   <= bin_ctx_d;
            tu_start_q  <= tu_start_d;
            tu_issued_q <= tu_issued_d;
            tu_depth_q  <= tu_depth_d;
            tu_blk_q    <= tu_blk_d;
            tu_luma_q   <= tu_luma_d;
            tu_cb_q     <= tu_cb_d;
            tu_cr_q     <= tu_cr_d;
            done_q      <= done_d;
        end
    end

    assign bin_ctx_addr    = bin_ctx_q;
    assign bin_val         = bin_val_q;
    assign bin_vld         = bin_vld_q;
    assign EPMode_trafo    = 1'b0;
    assign tu_start        = tu_start_q;
    assign tu_depth        = tu_depth_q;
    assign tu_blkIdx       = tu_blk_q;
    assign tu_cbf_luma     = tu_luma_q;
    assign tu_cbf_cb       = tu_cb_q;
    assign tu_cbf_cr       = tu_cr_q;
    assign trafo_done_intr = done_q;

endmodule

// File: tb/tb_qenc_trafo_fsm.sv
// Directed scoreboard bench for the transform-tree encoder FSM.
module tb_qenc_trafo_fsm;
    import qdec_cabac_package::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trafo_start;
    logic [2:0]  log2TrafoSize, maxTbLog2SizeY, minTbLog2SizeY, maxTrafoDepth;
    logic        intra_split_flag, pred_mode;
    logic [0:0]  split_transform_flag_d0;
    logic [3:0]  split_transform_flag_d1;
    logic [15:0] split_transform_flag_d2;
    logic        cbf_cb_d0, cbf_cr_d0, cbf_luma_d0;
    logic [3:0]  cbf_cb_d1, cbf_cr_d1, cbf_luma_d1;
    logic [15:0] cbf_cb_d2, cbf_cr_d2, cbf_luma_d2;
    logic [63:0] cbf_luma_d3;
    logic [9:0]  bin_ctx_addr;
    logic        bin_val, bin_vld, bin_rdy, EPMode_trafo;
    logic        tu_start, tu_cbf_luma, tu_cbf_cb, tu_cbf_cr, tu_done, trafo_done_intr;
    logic [2:0]  tu_depth;
    logic [1:0]  tu_blkIdx;

    typedef struct { logic [9:0] ctx; logic val; } bin_t;
    typedef struct { logic [2:0] d; logic [1:0] b; logic l; logic cb; logic cr; } tu_t;

    bin_t exp_bins[$];
    tu_t  exp_tus[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    qenc_trafo_fsm dut (
        .clk(clk), .rst_n(rst_n), .trafo_start(trafo_start),
        .log2TrafoSize(log2TrafoSize), .maxTbLog2SizeY(maxTbLog2SizeY),
        .minTbLog2SizeY(minTbLog2SizeY), .maxTrafoDepth(maxTrafoDepth),
        .intra_split_flag(intra_split_flag), .pred_mode(pred_mode),
        .split_transform_flag_d0(split_transform_flag_d0),
        .split_transform_flag_d1(split_transform_flag_d1),
        .split_transform_flag_d2(split_transform_flag_d2),
        .cbf_cb_d0(cbf_cb_d0), .cbf_cb_d1(cbf_cb_d1), .cbf_cb_d2(cbf_cb_d2),
        .cbf_cr_d0(cbf_cr_d0), .cbf_cr_d1(cbf_cr_d1), .cbf_cr_d2(cbf_cr_d2),
        .cbf_luma_d0(cbf_luma_d0), .cbf_luma_d1(cbf_luma_d1),
        .cbf_luma_d2(cbf_luma_d2), .cbf_luma_d3(cbf_luma_d3),
        .bin_ctx_addr(bin_ctx_addr), .bin_val(bin_val), .bin_vld(bin_vld),
        .bin_rdy(bin_rdy), .EPMode_trafo(EPMode_trafo),
        .tu_start(tu_start), .tu_depth(tu_depth), .tu_blkIdx(tu_blkIdx),
        .tu_cbf_luma(tu_cbf_luma), .tu_cbf_cb(tu_cbf_cb), .tu_cbf_cr(tu_cbf_cr),
        .tu_done(tu_done), .trafo_done_intr(trafo_done_intr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_bin(input logic [9:0] ctx, input logic val);
        bin_t b;
        b.ctx = ctx; b.val = val;
        exp_bins.push_back(b);
    endtask

    task automatic push_tu(input logic [2:0] d, input logic [1:0] b, input logic l,
                           input logic cb, input logic cr);
        tu_t t;
        t.d = d; t.b = b; t.l = l; t.cb = cb; t.cr = cr;
        exp_tus.push_back(t);
    endtask

    task automatic cfg(input logic [2:0] l2, input logic [2:0] mx, input logic [2:0] mn,
                       input logic [2:0] md, input logic isf, input logic pm);
        log2TrafoSize = l2; maxTbLog2SizeY = mx; minTbLog2SizeY = mn;
        maxTrafoDepth = md; intra_split_flag = isf; pred_mode = pm;
    endtask

    // compare a bin transfer happening at the next rising edge against the scoreboard
    task automatic check_xfer();
        bin_t b;
        if (bin_vld && bin_rdy) begin
            chk("bin_expected_avail", 64'(exp_bins.size() > 0), 64'd1);
            if (exp_bins.size() > 0) begin
                b = exp_bins.pop_front();
                chk("bin_ctx", 64'(bin_ctx_addr), 64'(b.ctx));
                chk("bin_val", 64'(bin_val), 64'(b.val));
            end
        end
    endtask

    task automatic run_tree(input int stall, input int first_lat, input bit spurious);
        int         stall_left;
        int         cyc;
        bit         done;
        bit         seen_vld;
        logic [9:0] cap_ctx;
        logic       cap_val;
        tu_t        t;
        stall_left = stall;
        cyc = 0; done = 0; seen_vld = 0; cap_ctx = '0; cap_val = 1'b0;
        @(negedge clk);
        trafo_start = 1'b1;
        bin_rdy     = (stall == 0);
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            trafo_start = 1'b0;
            tu_done     = 1'b0;
            if (!seen_vld && bin_vld) begin
                seen_vld = 1;
                if (first_lat > 0) chk("first_bin_latency", 64'(cyc), 64'(first_lat));
            end
            if (stall_left > 0) begin
                bin_rdy = 1'b0;
                if (stall_left < stall) begin
                    chk("stall_vld_held", 64'(bin_vld), 64'd1);
                    chk("stall_ctx_held", 64'(bin_ctx_addr), 64'(cap_ctx));
                    chk("stall_val_held", 64'(bin_val), 64'(cap_val));
                    stall_left--;
                end else if (bin_vld) begin
                    cap_ctx = bin_ctx_addr;
                    cap_val = bin_val;
                    stall_left--;
                end
            end else begin
                bin_rdy = 1'b1;
            end
            check_xfer();
            if (tu_start) begin
                chk("tu_expected_avail", 64'(exp_tus.size() > 0), 64'd1);
                if (exp_tus.size() > 0) begin
                    t = exp_tus.pop_front();
                    chk("tu_depth", 64'(tu_depth), 64'(t.d));
                    chk("tu_blkIdx", 64'(tu_blkIdx), 64'(t.b));
                    chk("tu_cbf_luma", 64'(tu_cbf_luma), 64'(t.l));
                    chk("tu_cbf_cb", 64'(tu_cbf_cb), 64'(t.cb));
                    chk("tu_cbf_cr", 64'(tu_cbf_cr), 64'(t.cr));
                end
                tu_done = 1'b1;
                if (spurious) trafo_start = 1'b1;
            end
            if (trafo_done_intr) done = 1;
        end
        tu_done     = 1'b0;
        trafo_start = 1'b0;
        chk("tree_done", 64'(done), 64'd1);
        @(negedge clk);
        chk("done_pulse_low", 64'(trafo_done_intr), 64'd0);
        chk("bins_left", 64'(exp_bins.size()), 64'd0);
        chk("tus_left", 64'(exp_tus.size()), 64'd0);
        exp_bins.delete();
        exp_tus.delete();
    endtask

    initial begin
        bit hit;
        rst_n = 1'b0; trafo_start = 1'b0; bin_rdy = 1'b0; tu_done = 1'b0;
        cfg(3'd3, 3'd5, 3'd2, 3'd1, 1'b0, 1'b1);
        split_transform_flag_d0 = '0; split_transform_flag_d1 = '0; split_transform_flag_d2 = '0;
        cbf_cb_d0 = 1'b0; cbf_cb_d1 = '0; cbf_cb_d2 = '0;
        cbf_cr_d0 = 1'b0; cbf_cr_d1 = '0; cbf_cr_d2 = '0;
        cbf_luma_d0 = 1'b0; cbf_luma_d1 = '0; cbf_luma_d2 = '0; cbf_luma_d3 = '0;
        repeat (3) @(negedge clk);
        chk("rst_bin_vld", 64'(bin_vld), 64'd0);
        chk("rst_tu_start", 64'(tu_start), 64'd0);
        chk("rst_done", 64'(trafo_done_intr), 64'd0);
        chk("rst_ctx", 64'(bin_ctx_addr), 64'd0);
        chk("rst_tu_fields", 64'({tu_depth, tu_blkIdx, tu_cbf_luma, tu_cbf_cb, tu_cbf_cr}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_bin", 64'(bin_vld), 64'd0);
        chk("epmode_zero", 64'(EPMode_trafo), 64'd0);

        // single leaf, every flag coded
        cfg(3'd3, 3'd5, 3'd2, 3'd1, 1'b0, 1'b1);
        split_transform_flag_d0 = 1'b0; cbf_cb_d0 = 1'b1; cbf_cr_d0 = 1'b0; cbf_luma_d0 = 1'b1;
        push_bin(10'd62, 1'b0); push_bin(10'd70, 1'b1); push_bin(10'd80, 1'b0); push_bin(10'd91, 1'b1);
        push_tu(3'd0, 2'd0, 1'b1, 1'b1, 1'b0);
        run_tree(0, 3, 1'b0);

        // same tree with the first bin back-pressured for five cycles
        push_bin(10'd62, 1'b0); push_bin(10'd70, 1'b1); push_bin(10'd80, 1'b0); push_bin(10'd91, 1'b1);
        push_tu(3'd0, 2'd0, 1'b1, 1'b1, 1'b0);
        run_tree(5, 3, 1'b0);

        // 64x64 over a 32 max TB: inferred split, four depth-1 leaves; stray trafo_start mid-tree
        cfg(3'd6, 3'd5, 3'd2, 3'd1, 1'b0, 1'b1);
        split_transform_flag_d0 = 1'b0; split_transform_flag_d1 = 4'b1111;
        cbf_cb_d0 = 1'b1; cbf_cr_d0 = 1'b1;
        cbf_cb_d1 = 4'b0101; cbf_cr_d1 = 4'b0011; cbf_luma_d1 = 4'b1010;
        push_bin(10'd70, 1'b1); push_bin(10'd80, 1'b1);
        push_bin(10'd71, 1'b1); push_bin(10'd81, 1'b1); push_bin(10'd90, 1'b0);
        push_bin(10'd71, 1'b0); push_bin(10'd81, 1'b1); push_bin(10'd90, 1'b1);
        push_bin(10'd71, 1'b1); push_bin(10'd81, 1'b0); push_bin(10'd90, 1'b0);
        push_bin(10'd71, 1'b0); push_bin(10'd81, 1'b0); push_bin(10'd90, 1'b1);
        push_tu(3'd1, 2'd0, 1'b0, 1'b1, 1'b1);
        push_tu(3'd1, 2'd1, 1'b1, 1'b0, 1'b1);
        push_tu(3'd1, 2'd2, 1'b0, 1'b1, 1'b0);
        push_tu(3'd1, 2'd3, 1'b1, 1'b0, 1'b0);
        run_tree(0, 4, 1'b1);

        // intra NxN on 8x8: 4x4 leaves inherit chroma cbf, depth-1 chroma/split inputs ignored
        cfg(3'd3, 3'd5, 3'd2, 3'd1, 1'b1, 1'b1);
        split_transform_flag_d1 = 4'b1111;
        cbf_cb_d0 = 1'b1; cbf_cr_d0 = 1'b0;
        cbf_cb_d1 = 4'b0000; cbf_cr_d1 = 4'b1111; cbf_luma_d1 = 4'b0110;
        push_bin(10'd70, 1'b1); push_bin(10'd80, 1'b0);
        push_bin(10'd90, 1'b0); push_bin(10'd90, 1'b1); push_bin(10'd90, 1'b1); push_bin(10'd90, 1'b0);
        push_tu(3'd1, 2'd0, 1'b0, 1'b1, 1'b0);
        push_tu(3'd1, 2'd1, 1'b1, 1'b1, 1'b0);
        push_tu(3'd1, 2'd2, 1'b1, 1'b1, 1'b0);
        push_tu(3'd1, 2'd3, 1'b0, 1'b1, 1'b0);
        run_tree(0, 4, 1'b0);

        // inter root with no chroma residual: luma cbf inferred as 1
        cfg(3'd3, 3'd5, 3'd2, 3'd1, 1'b0, 1'b0);
        split_transform_flag_d0 = 1'b0; cbf_cb_d0 = 1'b0; cbf_cr_d0 = 1'b0; cbf_luma_d0 = 1'b0;
        push_bin(10'd62, 1'b0); push_bin(10'd70, 1'b0); push_bin(10'd80, 1'b0);
        push_tu(3'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        run_tree(0, 3, 1'b0);

        // asynchronous reset while the cbf_cr bin is pending
        cfg(3'd3, 3'd5, 3'd2, 3'd1, 1'b0, 1'b1);
        split_transform_flag_d0 = 1'b0; cbf_cb_d0 = 1'b1; cbf_cr_d0 = 1'b0; cbf_luma_d0 = 1'b1;
        push_bin(10'd62, 1'b0); push_bin(10'd70, 1'b1);
        hit = 0;
        @(negedge clk);
        trafo_start = 1'b1;
        bin_rdy     = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            trafo_start = 1'b0;
            if (bin_vld && bin_ctx_addr == 10'd80) begin
                hit = 1;
                break;
            end
            check_xfer();
        end
        chk("reached_cbf_cr", 64'(hit), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_bin_vld", 64'(bin_vld), 64'd0);
        chk("async_rst_state", 64'(dut.state_q), 64'(IDLE_TRAFO));
        chk("async_rst_ctx", 64'(bin_ctx_addr), 64'd0);
        chk("async_rst_tu_start", 64'(tu_start), 64'd0);
        chk("pre_rst_bins_used", 64'(exp_bins.size()), 64'd0);
        exp_bins.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_bin(10'd62, 1'b0); push_bin(10'd70, 1'b1); push_bin(10'd80, 1'b0); push_bin(10'd91, 1'b1);
        push_tu(3'd0, 2'd0, 1'b1, 1'b1, 1'b0);
        run_tree(0, 3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qenc_trafo_fsm.md
QENC_TRAFO_FSM -- requirements
Module: qenc_trafo_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port trafo_start, input, 1 bit: one-cycle pulse that starts one CU transform tree; ignored outside IDLE_TRAFO.
REQ-004 SHALL have inputs log2TrafoSize[2:0] (3..6), maxTbLog2SizeY[2:0], minTbLog2SizeY[2:0], maxTrafoDepth[2:0], intra_split_flag, pred_mode: CU/SPS parameters, stable from trafo_start until trafo_done_intr.
REQ-005 SHALL have inputs split_transform_flag_d0[0], _d1[3:0], _d2[15:0]: the encoder's split decisions, indexed in z-order per depth.
REQ-006 SHALL have inputs cbf_cb_d0/_d1[3:0]/_d2[15:0], cbf_cr_d0/_d1/_d2 (same widths), cbf_luma_d0/_d1[3:0]/_d2[15:0]/_d3[63:0]: the encoder's cbf decisions, with the same indexing.
REQ-007 SHALL have outputs bin_ctx_addr[9:0], bin_val, bin_vld, plus input bin_rdy: bin stream to the arithmetic encoder.
REQ-008 SHALL have output EPMode_trafo, 1 bit, tied to 0 (all bins context-coded).
REQ-009 SHALL have outputs tu_start (pulse), tu_depth[2:0], tu_blkIdx[1:0], tu_cbf_luma, tu_cbf_cb, tu_cbf_cr, plus input tu_done (pulse): leaf hand-off to the TU encoder.
REQ-010 SHALL have output trafo_done_intr, 1 bit: one-cycle pulse when the tree is finished.

Function
REQ-011 SHALL implement the states IDLE_TRAFO, JUDGE_SPLIT_TRAFO, SPLIT_TRANSFORM_FLAG, JUDGE_CBF_CHROMA, CBF_CB, CBF_CR, JUDGE_TU, CBF_LUMA, TU_CODING, ITERATION_TRAFO, ENDING_TRAFO.
REQ-012 SHALL code split_transform_flag only when log2 <= maxTb, log2 > minTb, depth < maxTrafoDepth, and not (intra_split_flag and depth == 0).
REQ-013 SHALL, when split is not coded, infer it as 1 if log2 > maxTb or (intra_split_flag and depth == 0), else 0; the input vector is ignored in that case.
REQ-014 SHALL code cbf_cb (then cbf_cr) only when log2 > 2 and the parent value is 1 (parent = 1 at depth 0).
REQ-015 SHALL, when a chroma cbf is not coded, infer the parent value if log2 == 2 and depth > 0, else 0.
REQ-016 SHALL recurse on split = 1: depth+1, log2-1, blkIdx 0.
REQ-017 SHALL code cbf_luma only when pred_mode == intra, depth != 0, or either current chroma cbf is 1; otherwise infer cbf_luma = 1.
REQ-018 SHALL use context addresses CTXIDX_SPLIT_TRANSFORM_FLAG[5-log2], CTXIDX_CBF_CB[depth], CTXIDX_CBF_CR[depth], CTXIDX_CBF_LUMA[depth==0 ? 1 : 0].
REQ-019 SHALL assert bin_vld, registered, one cycle after entering a bin state.
REQ-020 SHALL hold bin_vld, bin_val and bin_ctx_addr stable until bin_rdy; a transfer occurs when bin_vld and bin_rdy are both high.
REQ-021 SHALL drop bin_vld the cycle after a transfer and leave the bin state on that same cycle; exactly one bin per element.
REQ-022 SHALL pulse tu_start one cycle after entering TU_CODING, with the tu_* fields valid and held until tu_done.
REQ-023 SHALL ignore tu_done outside TU_CODING.
REQ-024 SHALL, in ITERATION_TRAFO, advance blkIdx at the current depth; on blkIdx == 3, pop (depth-1, log2+1) repeatedly until an unfinished sibling exists or depth 0 completes, then go to ENDING_TRAFO.
REQ-025 SHALL pulse trafo_done_intr one cycle after ENDING_TRAFO, then return to IDLE_TRAFO.
REQ-026 SHALL wrap z-order indices modulo 4 per depth; child index = parent index*4 + blkIdx.

Reset
REQ-027 SHALL, on rst_n low at any time (including mid-tree), immediately force the state to IDLE_TRAFO, all outputs and counters to 0, and discard any pending bin or TU.

Structure
REQ-028 SHALL define t_state_trafo_enc and the CTXIDX_* tables in qdec_cabac_package (shared with the decoder), and SHALL NOT redefine them locally.
REQ-029 SHALL contain no sub-module; the TU encoder is external, connected through the tu_* handshake.

Verification
REQ-030 SHALL cover: log2=3, all bits coded, split_d0=0, cbf_cb=1, cbf_cr=0, pred=intra -> bins split 0, cb 1, cr 0, luma 1, then one tu_start (depth 0, blkIdx 0).
REQ-031 SHALL cover: log2=6, maxTb=5 -> no split bin, four depth-1 leaves, tu_start with blkIdx 0,1,2,3, then trafo_done_intr.
REQ-032 SHALL cover: bin_rdy low for 5 cycles on the first bin -> bin_vld and fields held stable, no state advance, exactly one transfer.
REQ-033 SHALL cover: intra_split=1, log2=3 -> depth-1 log2=2 leaves with no chroma bins, tu_cbf_cb equal to cbf_cb_d0.
REQ-034 SHALL cover: inter, depth 0, cbf_cb=cbf_cr=0 -> no luma bin, tu_cbf_luma=1.
REQ-035 SHALL cover: rst_n low during CBF_CR with bin_vld high -> bin_vld=0 asynchronously, state IDLE_TRAFO, next trafo_start runs cleanly.
